// File: rtl/mat_slot_allocator.sv
// mat_slot_allocator: matrix-storage ledger for the top-level controller.
// Keeps a table of matrix shapes (M x N); each shape owns a ring of SLOTS
// equal-size regions. Table lookups walk one row per cycle so the match
// logic stays narrow regardless of NUM_TYPES.
module mat_slot_allocator #(
   parameter int NUM_TYPES = 4,
   parameter int SLOTS     = 2,
   parameter int DIM_W     = 3,
   parameter int MAX_DIM   = 5,
   parameter int ADDR_W    = 8,
   parameter int MEM_DEPTH = 256,
   localparam int COUNT_W  = $clog2(SLOTS + 1),
   localparam int TIDX_W   = (NUM_TYPES > 1) ? $clog2(NUM_TYPES) : 1,
   localparam int UT_W     = $clog2(NUM_TYPES + 1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [1:0]         cmd_op,
   input  logic [DIM_W-1:0]   cmd_m,
   input  logic [DIM_W-1:0]   cmd_n,
   input  logic [COUNT_W-1:0] cmd_id,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [2:0]         rsp_status,
   output logic [ADDR_W-1:0]  rsp_addr,
   output logic [ADDR_W-1:0]  rsp_base,
   output logic [COUNT_W-1:0] rsp_count,
   output logic [TIDX_W-1:0]  rsp_type_idx,
   output logic               rsp_overwrite,
   output logic [UT_W-1:0]    used_types,
   output logic [ADDR_W:0]    free_ptr
);

   localparam int PTR_W  = (SLOTS > 1) ? $clog2(SLOTS) : 1;
   localparam int SIZE_W = 2 * DIM_W;
   localparam int FP_W   = ADDR_W + 1;
   // Wide enough that footprint/limit comparisons can never wrap.
   localparam int WIDE_W = ADDR_W + SIZE_W + COUNT_W + 2;

   localparam logic [1:0] OP_ALLOC   = 2'd0;
   localparam logic [1:0] OP_QUERY   = 2'd1;
   localparam logic [1:0] OP_RESOLVE = 2'd2;
   localparam logic [1:0] OP_CLEAR   = 2'd3;

   localparam logic [2:0] ST_OK       = 3'd0;
   localparam logic [2:0] ST_DIM      = 3'd1;
   localparam logic [2:0] ST_FULL     = 3'd2;
   localparam logic [2:0] ST_NOTFOUND = 3'd3;
   localparam logic [2:0] ST_BADID    = 3'd4;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SEARCH = 2'd1,
      S_EXEC   = 2'd2,
      S_RESP   = 2'd3
   } state_t;

   state_t r_state;
   state_t w_state_nxt;

   // Latched command and search progress
   logic [1:0]         r_op;
   logic [DIM_W-1:0]   r_m;
   logic [DIM_W-1:0]   r_n;
   logic [COUNT_W-1:0] r_id;
   logic [TIDX_W-1:0]  r_idx;
   logic               r_hit;
   logic [TIDX_W-1:0]  r_hit_idx;

   // Shape table
   logic [DIM_W-1:0]   r_tm     [NUM_TYPES];
   logic [DIM_W-1:0]   r_tn     [NUM_TYPES];
   logic [FP_W-1:0]    r_tstart [NUM_TYPES];
   logic [SIZE_W-1:0]  r_tsize  [NUM_TYPES];
   logic [PTR_W-1:0]   r_twp    [NUM_TYPES];
   logic [COUNT_W-1:0] r_tcnt   [NUM_TYPES];
   logic [UT_W-1:0]    r_used_types;
   logic [FP_W-1:0]    r_free_ptr;

   // Registered response
   logic               r_rsp_valid;
   logic [2:0]         r_rsp_status;
   logic [ADDR_W-1:0]  r_rsp_addr;
   logic [ADDR_W-1:0]  r_rsp_base;
   logic [COUNT_W-1:0] r_rsp_count;
   logic [TIDX_W-1:0]  r_rsp_type_idx;
   logic               r_rsp_overwrite;

   // Search / execute datapath
   logic               w_row_match;
   logic               w_idx_last;
   logic               w_dim_bad;
   logic [WIDE_W-1:0]  w_sz_new;
   logic [WIDE_W-1:0]  w_foot;
   logic [WIDE_W-1:0]  w_need;
   logic [WIDE_W-1:0]  w_hit_start;
   logic [WIDE_W-1:0]  w_hit_size;
   logic [PTR_W-1:0]   w_hit_ptr;
   logic [COUNT_W-1:0] w_hit_cnt;
   logic [PTR_W-1:0]   w_ptr_nxt;
   logic [COUNT_W-1:0] w_cnt_nxt;
   logic [WIDE_W-1:0]  w_wr_addr;
   logic [WIDE_W-1:0]  w_id_addr;

   logic [2:0]         w_ex_status;
   logic [ADDR_W-1:0]  w_ex_addr;
   logic [ADDR_W-1:0]  w_ex_base;
   logic [COUNT_W-1:0] w_ex_count;
   logic [TIDX_W-1:0]  w_ex_tidx;
   logic               w_ex_ovw;
   logic               w_upd_hit;
   logic               w_new_row;
   logic               w_clear;

   assign cmd_ready     = (r_state == S_IDLE);
   assign rsp_valid     = r_rsp_valid;
   assign rsp_status    = r_rsp_status;
   assign rsp_addr      = r_rsp_addr;
   assign rsp_base      = r_rsp_base;
   assign rsp_count     = r_rsp_count;
   assign rsp_type_idx  = r_rsp_type_idx;
   assign rsp_overwrite = r_rsp_overwrite;
   assign used_types    = r_used_types;
   assign free_ptr      = r_free_ptr;

   assign w_row_match = (UT_W'(r_idx) < r_used_types) &&
                        (r_tm[r_idx] == r_m) && (r_tn[r_idx] == r_n);
   assign w_idx_last  = (r_idx == TIDX_W'(NUM_TYPES - 1));
   assign w_dim_bad   = (r_m == '0) || (r_n == '0) ||
                        (WIDE_W'(r_m) > WIDE_W'(MAX_DIM)) ||
                        (WIDE_W'(r_n) > WIDE_W'(MAX_DIM));

   assign w_sz_new    = WIDE_W'(r_m) * WIDE_W'(r_n);
   assign w_foot      = WIDE_W'(SLOTS) * w_sz_new;
   assign w_need      = WIDE_W'(r_free_ptr) + w_foot;
   assign w_hit_start = WIDE_W'(r_tstart[r_hit_idx]);
   assign w_hit_size  = WIDE_W'(r_tsize[r_hit_idx]);
   assign w_hit_ptr   = r_twp[r_hit_idx];
   assign w_hit_cnt   = r_tcnt[r_hit_idx];
   assign w_ptr_nxt   = (w_hit_ptr == PTR_W'(SLOTS - 1)) ? PTR_W'(0)
                                                        : w_hit_ptr + PTR_W'(1);
   assign w_cnt_nxt   = (w_hit_cnt == COUNT_W'(SLOTS)) ? w_hit_cnt
                                                       : w_hit_cnt + COUNT_W'(1);
   assign w_wr_addr   = w_hit_start + WIDE_W'(w_hit_ptr) * w_hit_size;
   assign w_id_addr   = w_hit_start + (WIDE_W'(r_id) - WIDE_W'(1)) * w_hit_size;

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // FSM next-state: CLEAR bypasses the table walk
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (cmd_valid) begin
               if (cmd_op == OP_CLEAR) begin
                  w_state_nxt = S_EXEC;
               end else begin
                  w_state_nxt = S_SEARCH;
               end
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_SEARCH: begin
            if (w_idx_last) begin
               w_state_nxt = S_EXEC;
            end else begin
               w_state_nxt = S_SEARCH;
            end
         end
         S_EXEC: w_state_nxt = S_RESP;
         S_RESP: begin
            if (r_rsp_valid && rsp_ready) begin
               w_state_nxt = S_IDLE;
            end else begin
               w_state_nxt = S_RESP;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Command latch and one-row-per-cycle search, lowest matching row wins
   always_ff @(posedge clk) begin
      if (rst) begin
         r_op      <= 2'd0;
         r_m       <= '0;
         r_n       <= '0;
         r_id      <= '0;
         r_idx     <= '0;
         r_hit     <= 1'b0;
         r_hit_idx <= '0;
      end else if (r_state == S_IDLE) begin
         if (cmd_valid) begin
            r_op      <= cmd_op;
            r_m       <= cmd_m;
            r_n       <= cmd_n;
            r_id      <= cmd_id;
            r_idx     <= '0;
            r_hit     <= 1'b0;
            r_hit_idx <= '0;
         end
      end else if (r_state == S_SEARCH) begin
         if (w_row_match && !r_hit) begin
            r_hit     <= 1'b1;
            r_hit_idx <= r_idx;
         end
         if (!w_idx_last) begin
            r_idx <= r_idx + TIDX_W'(1);
         end
      end
   end

   // Execute decision: response fields and table update strobes
   always_comb begin
      w_ex_status = ST_OK;
      w_ex_addr   = '0;
      w_ex_base   = '0;
      w_ex_count  = '0;
      w_ex_tidx   = '0;
      w_ex_ovw    = 1'b0;
      w_upd_hit   = 1'b0;
      w_new_row   = 1'b0;
      w_clear     = 1'b0;
      case (r_op)
         OP_ALLOC: begin
            if (w_dim_bad) begin
               w_ex_status = ST_DIM;
            end else if (r_hit) begin
               w_ex_addr  = ADDR_W'(w_wr_addr);
               w_ex_base  = ADDR_W'(w_hit_start);
               w_ex_count = w_cnt_nxt;
               w_ex_tidx  = r_hit_idx;
               w_ex_ovw   = (w_hit_cnt == COUNT_W'(SLOTS));
               w_upd_hit  = 1'b1;
            end else if ((r_used_types >= UT_W'(NUM_TYPES)) ||
                         (w_need > WIDE_W'(MEM_DEPTH))) begin
               w_ex_status = ST_FULL;
            end else begin
               w_ex_addr  = ADDR_W'(r_free_ptr);
               w_ex_base  = ADDR_W'(r_free_ptr);
               w_ex_count = COUNT_W'(1);
               w_ex_tidx  = TIDX_W'(r_used_types);
               w_new_row  = 1'b1;
            end
         end
         OP_QUERY: begin
            if (w_dim_bad) begin
               w_ex_status = ST_DIM;
            end else if (!r_hit || (w_hit_cnt == '0)) begin
               w_ex_status = ST_NOTFOUND;
            end else begin
               w_ex_base  = ADDR_W'(w_hit_start);
               w_ex_count = w_hit_cnt;
               w_ex_tidx  = r_hit_idx;
            end
         end
         OP_RESOLVE: begin
            if (w_dim_bad) begin
               w_ex_status = ST_DIM;
            end else if (!r_hit) begin
               w_ex_status = ST_NOTFOUND;
            end else if ((r_id == '0) || (r_id > w_hit_cnt)) begin
               w_ex_status = ST_BADID;
            end else begin
               w_ex_addr  = ADDR_W'(w_id_addr);
               w_ex_base  = ADDR_W'(w_hit_start);
               w_ex_count = w_hit_cnt;
               w_ex_tidx  = r_hit_idx;
            end
         end
         OP_CLEAR: w_clear = 1'b1;
         default:  w_ex_status = ST_OK;
      endcase
   end

   // Shape table and allocation pointers, written only in EXEC
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_TYPES; i++) begin
            r_tm[i]     <= '0;
            r_tn[i]     <= '0;
            r_tstart[i] <= '0;
            r_tsize[i]  <= '0;
            r_twp[i]    <= '0;
            r_tcnt[i]   <= '0;
         end
         r_used_types <= '0;
         r_free_ptr   <= '0;
      end else if (r_state == S_EXEC) begin
         if (w_clear) begin
            for (int i = 0; i < NUM_TYPES; i++) begin
               r_twp[i]  <= '0;
               r_tcnt[i] <= '0;
            end
            r_used_types <= '0;
            r_free_ptr   <= '0;
         end else if (w_upd_hit) begin
            r_twp[r_hit_idx]  <= w_ptr_nxt;
            r_tcnt[r_hit_idx] <= w_cnt_nxt;
         end else if (w_new_row) begin
            r_tm[TIDX_W'(r_used_types)]     <= r_m;
            r_tn[TIDX_W'(r_used_types)]     <= r_n;
            r_tstart[TIDX_W'(r_used_types)] <= r_free_ptr;
            r_tsize[TIDX_W'(r_used_types)]  <= SIZE_W'(w_sz_new);
            r_twp[TIDX_W'(r_used_types)]    <= (SLOTS == 1) ? PTR_W'(0) : PTR_W'(1);
            r_tcnt[TIDX_W'(r_used_types)]   <= COUNT_W'(1);
            r_used_types <= r_used_types + UT_W'(1);
            r_free_ptr   <= FP_W'(w_need);
         end
      end
   end

   // Response register: loaded in EXEC, held until the handshake
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rsp_valid     <= 1'b0;
         r_rsp_status    <= 3'd0;
         r_rsp_addr      <= '0;
         r_rsp_base      <= '0;
         r_rsp_count     <= '0;
         r_rsp_type_idx  <= '0;
         r_rsp_overwrite <= 1'b0;
      end else if (r_state == S_EXEC) begin
         r_rsp_valid     <= 1'b1;
         r_rsp_status    <= w_ex_status;
         r_rsp_addr      <= w_ex_addr;
         r_rsp_base      <= w_ex_base;
         r_rsp_count     <= w_ex_count;
         r_rsp_type_idx  <= w_ex_tidx;
         r_rsp_overwrite <= w_ex_ovw;
      end else if ((r_state == S_RESP) && r_rsp_valid && rsp_ready) begin
         r_rsp_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mat_slot_allocator.sv
// Directed bench for mat_slot_allocator. Two instances share the command
// and response-ready inputs: dut (MEM_DEPTH=256) and dut_b (MEM_DEPTH=64).
module tb_mat_slot_allocator;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       cmd_valid = 1'b0;
   logic [1:0] cmd_op = 2'd0;
   logic [2:0] cmd_m = 3'd0;
   logic [2:0] cmd_n = 3'd0;
   logic [1:0] cmd_id = 2'd0;
   logic       rsp_ready = 1'b0;

   logic       cmd_ready, rsp_valid, rsp_overwrite;
   logic [2:0] rsp_status;
   logic [7:0] rsp_addr, rsp_base;
   logic [1:0] rsp_count, rsp_type_idx;
   logic [2:0] used_types;
   logic [8:0] free_ptr;

   logic       cmd_ready_b, rsp_valid_b, rsp_overwrite_b;
   logic [2:0] rsp_status_b;
   logic [7:0] rsp_addr_b, rsp_base_b;
   logic [1:0] rsp_count_b, rsp_type_idx_b;
   logic [2:0] used_types_b;
   logic [8:0] free_ptr_b;

   int n_vec = 0;
   int n_err = 0;

   // captured response of the last do_cmd
   int         lat;
   logic [2:0] st, st_b;
   logic [7:0] ad, bs;
   logic [1:0] ct, ti;
   logic       ow;

   mat_slot_allocator dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_m(cmd_m), .cmd_n(cmd_n), .cmd_id(cmd_id),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_status(rsp_status),
      .rsp_addr(rsp_addr), .rsp_base(rsp_base), .rsp_count(rsp_count),
      .rsp_type_idx(rsp_type_idx), .rsp_overwrite(rsp_overwrite),
      .used_types(used_types), .free_ptr(free_ptr)
   );

   mat_slot_allocator #(.MEM_DEPTH(64)) dut_b (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_b),
      .cmd_op(cmd_op), .cmd_m(cmd_m), .cmd_n(cmd_n), .cmd_id(cmd_id),
      .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready), .rsp_status(rsp_status_b),
      .rsp_addr(rsp_addr_b), .rsp_base(rsp_base_b), .rsp_count(rsp_count_b),
      .rsp_type_idx(rsp_type_idx_b), .rsp_overwrite(rsp_overwrite_b),
      .used_types(used_types_b), .free_ptr(free_ptr_b)
   );

   always #5 clk = ~clk;

   // Issue one command, wait (bounded) for the response, capture it, handshake.
   // On timeout the captured status is 7, which no comparison expects.
   task automatic do_cmd(input logic [1:0] op, input int m, input int n, input int id);
      int guard;
      guard = 0;
      while (!cmd_ready && guard < 50) begin
         @(posedge clk); #1; guard++;
      end
      cmd_op = op; cmd_m = 3'(m); cmd_n = 3'(n); cmd_id = 2'(id);
      cmd_valid = 1'b1;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      lat = -1;
      for (int c = 1; c <= 50; c++) begin
         @(posedge clk); #1;
         if (rsp_valid) begin
            lat = c;
            break;
         end
      end
      if (lat < 0) begin
         st = 3'd7; st_b = 3'd7;
      end else begin
         st = rsp_status; st_b = rsp_status_b; ad = rsp_addr; bs = rsp_base;
         ct = rsp_count; ti = rsp_type_idx; ow = rsp_overwrite;
         rsp_ready = 1'b1;
         @(posedge clk); #1;
         rsp_ready = 1'b0;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      n_vec++;
      if ({cmd_ready, rsp_valid, rsp_status, rsp_addr, used_types, free_ptr} !== {1'b1, 1'b0, 3'd0, 8'd0, 3'd0, 9'd0}) begin
         n_err++;
         $display("FAIL reset: rdy=%0b vld=%0b st=%0d addr=%0d used=%0d free=%0d want 1 0 0 0 0 0",
                  cmd_ready, rsp_valid, rsp_status, rsp_addr, used_types, free_ptr);
      end
   endtask

   task automatic test_alloc_ring();
      do_cmd(2'd0, 2, 3, 0);
      n_vec++;
      if (lat !== 5) begin n_err++; $display("FAIL alloc_latency: got %0d want 5", lat); end
      n_vec++;
      if ({st, ad, ti, ct, ow, free_ptr} !== {3'd0, 8'd0, 2'd0, 2'd1, 1'b0, 9'd12}) begin
         n_err++;
         $display("FAIL alloc1: st=%0d addr=%0d ti=%0d ct=%0d ow=%0b free=%0d want 0 0 0 1 0 12", st, ad, ti, ct, ow, free_ptr);
      end
      do_cmd(2'd0, 2, 3, 0);
      n_vec++;
      if ({st, ad, ct, ow} !== {3'd0, 8'd6, 2'd2, 1'b0}) begin
         n_err++; $display("FAIL alloc2: st=%0d addr=%0d ct=%0d ow=%0b want 0 6 2 0", st, ad, ct, ow);
      end
      do_cmd(2'd0, 2, 3, 0);
      n_vec++;
      if ({st, ad, ct, ow, free_ptr} !== {3'd0, 8'd0, 2'd2, 1'b1, 9'd12}) begin
         n_err++; $display("FAIL alloc3_overwrite: st=%0d addr=%0d ct=%0d ow=%0b free=%0d want 0 0 2 1 12", st, ad, ct, ow, free_ptr);
      end
   endtask

   task automatic test_resolve();
      do_cmd(2'd0, 3, 2, 0);
      n_vec++;
      if ({st, ti, ad, free_ptr} !== {3'd0, 2'd1, 8'd12, 9'd24}) begin
         n_err++; $display("FAIL alloc_3x2: st=%0d ti=%0d addr=%0d free=%0d want 0 1 12 24", st, ti, ad, free_ptr);
      end
      do_cmd(2'd2, 2, 3, 2);
      n_vec++;
      if ({st, ad} !== {3'd0, 8'd6}) begin n_err++; $display("FAIL resolve_id2: st=%0d addr=%0d want 0 6", st, ad); end
      do_cmd(2'd2, 2, 3, 3);
      n_vec++;
      if ({st, ad} !== {3'd4, 8'd0}) begin n_err++; $display("FAIL resolve_badid: st=%0d addr=%0d want 4 0", st, ad); end
      do_cmd(2'd2, 3, 2, 1);
      n_vec++;
      if ({st, ad} !== {3'd0, 8'd12}) begin n_err++; $display("FAIL resolve_3x2: st=%0d addr=%0d want 0 12", st, ad); end
   endtask

   task automatic test_errors();
      do_cmd(2'd1, 4, 4, 0);
      n_vec++;
      if (st !== 3'd3) begin n_err++; $display("FAIL query_miss: st=%0d want 3", st); end
      do_cmd(2'd1, 2, 3, 0);
      n_vec++;
      if ({st, bs, ct, ti} !== {3'd0, 8'd0, 2'd2, 2'd0}) begin
         n_err++; $display("FAIL query_hit: st=%0d base=%0d ct=%0d ti=%0d want 0 0 2 0", st, bs, ct, ti);
      end
      do_cmd(2'd0, 0, 3, 0);
      n_vec++;
      if ({st, ad, ow} !== {3'd1, 8'd0, 1'b0}) begin n_err++; $display("FAIL dim_zero: st=%0d addr=%0d want 1 0", st, ad); end
      do_cmd(2'd0, 6, 1, 0);
      n_vec++;
      if (st !== 3'd1) begin n_err++; $display("FAIL dim_big: st=%0d want 1", st); end
      n_vec++;
      if ({used_types, free_ptr} !== {3'd2, 9'd24}) begin
         n_err++; $display("FAIL dim_unchanged: used=%0d free=%0d want 2 24", used_types, free_ptr);
      end
   endtask

   task automatic test_table_full();
      do_cmd(2'd0, 5, 5, 0);
      n_vec++;
      if ({st, ad, ti} !== {3'd0, 8'd24, 2'd2}) begin n_err++; $display("FAIL alloc_5x5: st=%0d addr=%0d ti=%0d want 0 24 2", st, ad, ti); end
      do_cmd(2'd0, 4, 5, 0);
      n_vec++;
      if ({st, ad, ti, free_ptr} !== {3'd0, 8'd74, 2'd3, 9'd114}) begin
         n_err++; $display("FAIL alloc_4x5: st=%0d addr=%0d ti=%0d free=%0d want 0 74 3 114", st, ad, ti, free_ptr);
      end
      do_cmd(2'd0, 5, 4, 0);
      n_vec++;
      if ({st, used_types, free_ptr} !== {3'd2, 3'd4, 9'd114}) begin
         n_err++; $display("FAIL table_full: st=%0d used=%0d free=%0d want 2 4 114", st, used_types, free_ptr);
      end
   endtask

   task automatic test_mem_full();
      do_cmd(2'd3, 0, 0, 0);
      n_vec++;
      if ({lat, st, used_types, free_ptr, free_ptr_b} !== {32'sd1, 3'd0, 3'd0, 9'd0, 9'd0}) begin
         n_err++; $display("FAIL clear: lat=%0d st=%0d used=%0d free=%0d free_b=%0d want 1 0 0 0 0", lat, st, used_types, free_ptr, free_ptr_b);
      end
      do_cmd(2'd0, 5, 5, 0);
      n_vec++;
      if ({st_b, free_ptr_b} !== {3'd0, 9'd50}) begin n_err++; $display("FAIL mem64_5x5: st=%0d free=%0d want 0 50", st_b, free_ptr_b); end
      do_cmd(2'd0, 3, 3, 0);
      n_vec++;
      if ({st_b, free_ptr_b, used_types_b} !== {3'd2, 9'd50, 3'd1}) begin
         n_err++; $display("FAIL mem64_full: st=%0d free=%0d used=%0d want 2 50 1", st_b, free_ptr_b, used_types_b);
      end
      n_vec++;
      if ({st, free_ptr} !== {3'd0, 9'd68}) begin n_err++; $display("FAIL mem256_3x3: st=%0d free=%0d want 0 68", st, free_ptr); end
   endtask

   task automatic test_back_to_back_hold();
      int got;
      got = 0;
      cmd_op = 2'd0; cmd_m = 3'd2; cmd_n = 3'd3; cmd_id = 2'd0;
      cmd_valid = 1'b1;
      @(posedge clk); #1;
      cmd_op = 2'd1;  // a QUERY stays presented while the response is held
      for (int c = 0; c < 50 && !rsp_valid; c++) begin
         @(posedge clk); #1;
      end
      for (int c = 0; c < 10; c++) begin
         n_vec++;
         if ({rsp_valid, cmd_ready, rsp_status, rsp_addr, rsp_type_idx, rsp_count} !== {1'b1, 1'b0, 3'd0, 8'd68, 2'd2, 2'd1}) begin
            n_err++;
            $display("FAIL hold_cycle%0d: vld=%0b rdy=%0b st=%0d addr=%0d ti=%0d ct=%0d want 1 0 0 68 2 1",
                     c, rsp_valid, cmd_ready, rsp_status, rsp_addr, rsp_type_idx, rsp_count);
         end
         @(posedge clk); #1;
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      rsp_ready = 1'b0;
      n_vec++;
      if ({rsp_valid, cmd_ready, used_types, free_ptr} !== {1'b0, 1'b1, 3'd3, 9'd80}) begin
         n_err++; $display("FAIL hold_release: vld=%0b rdy=%0b used=%0d free=%0d want 0 1 3 80", rsp_valid, cmd_ready, used_types, free_ptr);
      end
      @(posedge clk); #1;
      n_vec++;
      if ({rsp_valid, cmd_ready} !== {1'b0, 1'b1}) begin
         n_err++; $display("FAIL handshake_cmd_ignored: vld=%0b rdy=%0b want 0 1", rsp_valid, cmd_ready);
      end
   endtask

   task automatic test_reset_mid_search();
      cmd_op = 2'd0; cmd_m = 3'd2; cmd_n = 3'd3;
      cmd_valid = 1'b1;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      n_vec++;
      if ({cmd_ready, rsp_valid, rsp_status, rsp_addr, rsp_base, rsp_count, rsp_type_idx, rsp_overwrite, used_types, free_ptr}
          !== {1'b1, 1'b0, 3'd0, 8'd0, 8'd0, 2'd0, 2'd0, 1'b0, 3'd0, 9'd0}) begin
         n_err++;
         $display("FAIL reset_mid: rdy=%0b vld=%0b st=%0d addr=%0d base=%0d used=%0d free=%0d want 1 0 0 0 0 0 0",
                  cmd_ready, rsp_valid, rsp_status, rsp_addr, rsp_base, used_types, free_ptr);
      end
      repeat (8) @(posedge clk);
      #1;
      n_vec++;
      if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_abort: vld=%0b want 0", rsp_valid); end
   endtask

   task automatic test_clear();
      do_cmd(2'd0, 2, 3, 0);
      n_vec++;
      if ({st, ad, ti} !== {3'd0, 8'd0, 2'd0}) begin n_err++; $display("FAIL post_reset_alloc: st=%0d addr=%0d ti=%0d want 0 0 0", st, ad, ti); end
      do_cmd(2'd3, 0, 0, 0);
      do_cmd(2'd1, 2, 3, 0);
      n_vec++;
      if ({st, ct} !== {3'd3, 2'd0}) begin n_err++; $display("FAIL clear_query: st=%0d ct=%0d want 3 0", st, ct); end
   endtask

   initial begin
      test_reset();
      test_alloc_ring();
      test_resolve();
      test_errors();
      test_table_full();
      test_mem_full();
      test_back_to_back_hold();
      test_reset_mid_search();
      test_clear();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
